// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO, power-of-two depth,
// level/threshold flags, registered read data, sticky error flags.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [AW:0]           level,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_fire;
  logic                  wr_fire;

  assign empty        = (level == '0);
  assign full         = (level == FULL_LVL);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // a full FIFO still accepts a write when a read frees a slot
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      unique case ({wr_fire, rd_fire})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

  // set wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_fire) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
